// File: rtl/multi_rate_clock_divider.sv
// Square-wave clock divider with four selectable half-period divisors, run/stop and a tick enable.
// Optional macro CLKDIV_INPUT_SYNC_EN adds 2-flop synchronisers on rate_sel and run.
module multi_rate_clock_divider #(
  parameter int CNT_W = 24,
  parameter int DIV0  = 5_000_000,
  parameter int DIV1  = 1_000_000,
  parameter int DIV2  = 500_000,
  parameter int DIV3  = 100_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] rate_sel,
  input  logic       run,
  output logic       clock_out,
  output logic       tick,
  output logic [1:0] rate_active
);

  typedef enum logic {STOPPED, RUNNING} state_t;

  localparam logic [CNT_W-1:0] TERM0 = CNT_W'(DIV0 - 1);
  localparam logic [CNT_W-1:0] TERM1 = CNT_W'(DIV1 - 1);
  localparam logic [CNT_W-1:0] TERM2 = CNT_W'(DIV2 - 1);
  localparam logic [CNT_W-1:0] TERM3 = CNT_W'(DIV3 - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] counter, counter_d, term;
  logic             clock_out_d, tick_d;
  logic [1:0]       rate_active_d;
  logic [1:0]       rate_eff;
  logic             run_eff;

`ifdef CLKDIV_INPUT_SYNC_EN
  logic [1:0] rate_meta, rate_sync;
  logic       run_meta, run_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rate_meta <= '0;
      rate_sync <= '0;
      run_meta  <= 1'b0;
      run_sync  <= 1'b0;
    end else begin
      rate_meta <= rate_sel;
      rate_sync <= rate_meta;
      run_meta  <= run;
      run_sync  <= run_meta;
    end
  end

  assign rate_eff = rate_sync;
  assign run_eff  = run_sync;
`else
  assign rate_eff = rate_sel;
  assign run_eff  = run;
`endif

  always_comb begin
    case (rate_active)
      2'd0:    term = TERM0;
      2'd1:    term = TERM1;
      2'd2:    term = TERM2;
      default: term = TERM3;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= STOPPED;
      counter     <= '0;
      clock_out   <= 1'b0;
      tick        <= 1'b0;
      rate_active <= 2'd0;
    end else begin
      state       <= state_d;
      counter     <= counter_d;
      clock_out   <= clock_out_d;
      tick        <= tick_d;
      rate_active <= rate_active_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      STOPPED: if (run_eff)  state_d = RUNNING;
      RUNNING: if (!run_eff) state_d = STOPPED;
      default: state_d = STOPPED;
    endcase
  end

  // A new rate is only picked up when a half-period ends, so clock_out never glitches.
  always_comb begin
    counter_d     = counter;
    clock_out_d   = clock_out;
    tick_d        = 1'b0;
    rate_active_d = rate_active;
    case (state)
      STOPPED: begin
        counter_d     = '0;
        rate_active_d = rate_eff;
      end
      RUNNING: begin
        if (!run_eff) begin
          counter_d = '0;
        end else if (counter == term) begin
          counter_d     = '0;
          clock_out_d   = ~clock_out;
          tick_d        = 1'b1;
          rate_active_d = rate_eff;
        end else begin
          counter_d = counter + 1'b1;
        end
      end
      default: counter_d = '0;
    endcase
  end

endmodule

// File: tb/tb_multi_rate_clock_divider.sv
// Self-checking bench for multi_rate_clock_divider: vector table, hand sequences and a randomized run
// compared against a countdown-based reference model.
module tb_multi_rate_clock_divider;

  typedef struct {
    logic [1:0] sel;
    logic       run;
    logic       exp_clk;
    logic       exp_tick;
    logic [1:0] exp_rate;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic [1:0] rate_sel;
  logic       run;
  logic       clock_out;
  logic       tick;
  logic [1:0] rate_active;

  int assertions;
  int failures;

  int         div_tab[4] = '{4, 2, 3, 1};
  logic       m_running;
  int         m_rem;
  logic [1:0] m_act;
  logic       m_clk;
  logic       m_tick;
  logic [1:0] p1_sel, p2_sel;
  logic       p1_run, p2_run;

  vec_t vecs[24];

  multi_rate_clock_divider #(
    .CNT_W(4), .DIV0(4), .DIV1(2), .DIV2(3), .DIV3(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rate_sel(rate_sel),
    .run(run),
    .clock_out(clock_out),
    .tick(tick),
    .rate_active(rate_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    m_running = 1'b0;
    m_rem     = div_tab[0];
    m_act     = 2'd0;
    m_clk     = 1'b0;
    m_tick    = 1'b0;
    p1_sel = 2'd0; p2_sel = 2'd0;
    p1_run = 1'b0; p2_run = 1'b0;
  endtask

  // The model counts cycles remaining in the current half-period down to zero.
  task automatic modelStep(input logic [1:0] sel, input logic rn);
    logic [1:0] e_sel;
    logic       e_run;
`ifdef CLKDIV_INPUT_SYNC_EN
    e_sel = p2_sel; e_run = p2_run;
    p2_sel = p1_sel; p2_run = p1_run;
    p1_sel = sel;    p1_run = rn;
`else
    e_sel = sel; e_run = rn;
`endif
    if (!m_running) begin
      m_act     = e_sel;
      m_rem     = div_tab[e_sel];
      m_tick    = 1'b0;
      m_running = e_run;
    end else if (!e_run) begin
      m_running = 1'b0;
      m_tick    = 1'b0;
      m_rem     = div_tab[m_act];
    end else begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_clk  = ~m_clk;
        m_tick = 1'b1;
        m_act  = e_sel;
        m_rem  = div_tab[e_sel];
      end else begin
        m_tick = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input logic rn);
    rate_sel = sel;
    run      = rn;
    @(posedge clk);
    modelStep(sel, rn);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic exp_clk, input logic exp_tick,
                             input logic [1:0] exp_rate);
    assertions++;
    if (clock_out !== exp_clk) begin
      failures++;
      $display("[TB] FAIL %s clock_out: got %0b, expected %0b at %0t", name, clock_out, exp_clk, $time);
    end
    assertions++;
    if (tick !== exp_tick) begin
      failures++;
      $display("[TB] FAIL %s tick: got %0b, expected %0b at %0t", name, tick, exp_tick, $time);
    end
    assertions++;
    if (rate_active !== exp_rate) begin
      failures++;
      $display("[TB] FAIL %s rate_active: got %0d, expected %0d at %0t", name, rate_active, exp_rate, $time);
    end
  endtask

  initial begin
    logic [1:0] r_sel;
    logic       r_run;
    assertions = 0;
    failures   = 0;
    reset_n  = 1'b0;
    rate_sel = 2'd0;
    run      = 1'b0;
    modelReset();
    #12;
    checkOutput("reset", 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    reset_n = 1'b1;

`ifndef CLKDIV_INPUT_SYNC_EN
    // Rate 0 from reset, mid-period switch to rate 1, then rate 3 and a stop.
    vecs[0]  = '{2'd0, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{2'd0, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{2'd0, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{2'd0, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[4]  = '{2'd0, 1'b1, 1'b1, 1'b1, 2'd0};
    vecs[5]  = '{2'd0, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[6]  = '{2'd0, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[7]  = '{2'd0, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[8]  = '{2'd0, 1'b1, 1'b0, 1'b1, 2'd0};
    vecs[9]  = '{2'd0, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[10] = '{2'd1, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[11] = '{2'd1, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[12] = '{2'd1, 1'b1, 1'b1, 1'b1, 2'd1};
    vecs[13] = '{2'd1, 1'b1, 1'b1, 1'b0, 2'd1};
    vecs[14] = '{2'd1, 1'b1, 1'b0, 1'b1, 2'd1};
    vecs[15] = '{2'd1, 1'b1, 1'b0, 1'b0, 2'd1};
    vecs[16] = '{2'd1, 1'b1, 1'b1, 1'b1, 2'd1};
    vecs[17] = '{2'd3, 1'b1, 1'b1, 1'b0, 2'd1};
    vecs[18] = '{2'd3, 1'b1, 1'b0, 1'b1, 2'd3};
    vecs[19] = '{2'd3, 1'b1, 1'b1, 1'b1, 2'd3};
    vecs[20] = '{2'd3, 1'b1, 1'b0, 1'b1, 2'd3};
    vecs[21] = '{2'd3, 1'b1, 1'b1, 1'b1, 2'd3};
    vecs[22] = '{2'd3, 1'b0, 1'b1, 1'b0, 2'd3};
    vecs[23] = '{2'd3, 1'b0, 1'b1, 1'b0, 2'd3};
    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].run);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_clk, vecs[i].exp_tick, vecs[i].exp_rate);
    end

    // Stop at counter=1 on rate 2, hold stopped 5 cycles, then restart.
    applyStimulus(2'd2, 1'b1);
    checkOutput("s4_enter", 1'b1, 1'b0, 2'd2);
    applyStimulus(2'd2, 1'b1);
    checkOutput("s4_count", 1'b1, 1'b0, 2'd2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'd2, 1'b0);
      checkOutput("s4_stopped", 1'b1, 1'b0, 2'd2);
    end
    applyStimulus(2'd2, 1'b1);
    checkOutput("s4_reenter", 1'b1, 1'b0, 2'd2);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(2'd2, 1'b1);
      checkOutput("s4_wait", 1'b1, 1'b0, 2'd2);
    end
    applyStimulus(2'd2, 1'b1);
    checkOutput("s4_first_toggle", 1'b0, 1'b1, 2'd2);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(2'd2, 1'b1);
      checkOutput("s5_wait", 1'b0, 1'b0, 2'd2);
    end
    applyStimulus(2'd2, 1'b1);
    checkOutput("s5_high", 1'b1, 1'b1, 2'd2);

    // Reset lands mid-cycle with clock_out high; outputs must clear before any edge.
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("s5_async_reset", 1'b0, 1'b0, 2'd0);
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;
`else
    // With synchronisers the first toggle lands two edges later than unsynchronised.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'd0, 1'b1);
      checkOutput("s6_wait", 1'b0, 1'b0, 2'd0);
    end
    applyStimulus(2'd0, 1'b1);
    checkOutput("s6_first_toggle", 1'b1, 1'b1, 2'd0);
`endif

    r_sel = 2'd0;
    r_run = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) r_sel = 2'($urandom_range(0, 3));
      r_run = ($urandom_range(0, 7) != 0);
      if (i == 200) begin
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rand_reset", m_clk, m_tick, m_act);
        @(negedge clk);
        reset_n = 1'b1;
      end
      applyStimulus(r_sel, r_run);
      checkOutput("random", m_clk, m_tick, m_act);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
